// File: rtl/finger_match_pkg.sv
// Shared types and widths for the fingerprint match-score datapath.
package finger_match_pkg;

    localparam int unsigned ACC_W_DEF = 48;
    localparam int unsigned PROD_W    = 32;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StCompare,
        StDone
    } fsmState_t;

endpackage

// File: rtl/score_sat_adder.sv
// Combinational saturating add of a zero-extended product onto the window accumulator.
module score_sat_adder
    import finger_match_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    logic [ACC_W:0] wide;

    // One extra bit catches the carry out; ACC_W is assumed >= PROD_W.
    always_comb begin
        wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
        sat  = wide[ACC_W];
        sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/match_score_accumulator.sv
// Sums PIX_COUNT pixel products per window with saturation, then compares against a threshold.
module match_score_accumulator
    import finger_match_pkg::*;
#(
    parameter int unsigned PIX_COUNT = 4096,
    parameter int unsigned ACC_W     = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ACC_W-1:0]  threshold,
    input  logic              prod_valid,
    input  logic [31:0]       prod,
    output logic              prod_ready,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  score,
    output logic              match,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(PIX_COUNT - 1);

    fsmState_t        stateQ, stateD;
    logic [ACC_W-1:0] accQ, accD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [ACC_W-1:0] thrQ, thrD;
    logic             satFlagQ, satFlagD;
    logic [ACC_W-1:0] scoreQ, scoreD;
    logic             matchQ, matchD;
    logic             overflowQ, overflowD;
    logic             busyQ, busyD;
    logic             readyQ, readyD;
    logic             doneQ, doneD;

    logic [ACC_W-1:0] sumW;
    logic             satW;

    score_sat_adder #(
        .ACC_W (ACC_W)
    ) uAdder (
        .acc    (accQ),
        .addend (prod),
        .sum    (sumW),
        .sat    (satW)
    );

    always_comb begin
        stateD    = stateQ;
        accD      = accQ;
        cntD      = cntQ;
        thrD      = thrQ;
        satFlagD  = satFlagQ;
        scoreD    = scoreQ;
        matchD    = matchQ;
        overflowD = overflowQ;

        case (stateQ)
            StIdle: begin
                if (start) begin
                    stateD   = StAccum;
                    accD     = '0;
                    cntD     = '0;
                    thrD     = threshold;
                    satFlagD = 1'b0;
                end
            end
            StAccum: begin
                if (prod_valid) begin
                    accD     = sumW;
                    satFlagD = satFlagQ | satW;
                    cntD     = cntQ + 1'b1;
                    if (cntQ == LastIdx) begin
                        stateD = StCompare;
                    end
                end
            end
            StCompare: begin
                scoreD    = accQ;
                matchD    = (accQ >= thrQ);
                overflowD = satFlagQ;
                stateD    = StDone;
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase

        // Handshake/status flags are registered copies decoded from the next state.
        busyD  = (stateD == StAccum) || (stateD == StCompare);
        readyD = (stateD == StAccum);
        doneD  = (stateD == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= StIdle;
            accQ      <= '0;
            cntQ      <= '0;
            thrQ      <= '0;
            satFlagQ  <= 1'b0;
            scoreQ    <= '0;
            matchQ    <= 1'b0;
            overflowQ <= 1'b0;
            busyQ     <= 1'b0;
            readyQ    <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            accQ      <= accD;
            cntQ      <= cntD;
            thrQ      <= thrD;
            satFlagQ  <= satFlagD;
            scoreQ    <= scoreD;
            matchQ    <= matchD;
            overflowQ <= overflowD;
            busyQ     <= busyD;
            readyQ    <= readyD;
            doneQ     <= doneD;
        end
    end

    assign prod_ready = readyQ;
    assign busy       = busyQ;
    assign done       = doneQ;
    assign score      = scoreQ;
    assign match      = matchQ;
    assign overflow   = overflowQ;

endmodule

// File: tb/tb_match_score_accumulator.sv
// Directed bench: three accumulator instances covering default width, a 33-bit saturating
// configuration and a single-product window.
module tb_match_score_accumulator;

    logic clk;
    logic reset;

    // Instance A: PIX_COUNT=4, ACC_W=48
    logic        startA, pvA, readyA, busyA, doneA, matchA, ovfA;
    logic [47:0] thrA, scoreA;
    logic [31:0] pdA;
    // Instance B: PIX_COUNT=3, ACC_W=33
    logic        startB, pvB, readyB, busyB, doneB, matchB, ovfB;
    logic [32:0] thrB, scoreB;
    logic [31:0] pdB;
    // Instance C: PIX_COUNT=1, ACC_W=48
    logic        startC, pvC, readyC, busyC, doneC, matchC, ovfC;
    logic [47:0] thrC, scoreC;
    logic [31:0] pdC;

    int vecs;
    int errs;
    int doneCountA;

    match_score_accumulator #(.PIX_COUNT(4), .ACC_W(48)) dutA (
        .clk        (clk),
        .reset      (reset),
        .start      (startA),
        .threshold  (thrA),
        .prod_valid (pvA),
        .prod       (pdA),
        .prod_ready (readyA),
        .busy       (busyA),
        .done       (doneA),
        .score      (scoreA),
        .match      (matchA),
        .overflow   (ovfA)
    );

    match_score_accumulator #(.PIX_COUNT(3), .ACC_W(33)) dutB (
        .clk        (clk),
        .reset      (reset),
        .start      (startB),
        .threshold  (thrB),
        .prod_valid (pvB),
        .prod       (pdB),
        .prod_ready (readyB),
        .busy       (busyB),
        .done       (doneB),
        .score      (scoreB),
        .match      (matchB),
        .overflow   (ovfB)
    );

    match_score_accumulator #(.PIX_COUNT(1), .ACC_W(48)) dutC (
        .clk        (clk),
        .reset      (reset),
        .start      (startC),
        .threshold  (thrC),
        .prod_valid (pvC),
        .prod       (pdC),
        .prod_ready (readyC),
        .busy       (busyC),
        .done       (doneC),
        .score      (scoreC),
        .match      (matchC),
        .overflow   (ovfC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (doneA === 1'b1) doneCountA = doneCountA + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startWinA(input logic [47:0] thr);
        startA = 1'b1;
        thrA   = thr;
        tick();
        startA = 1'b0;
    endtask

    task automatic sendA(input logic [31:0] v);
        pvA = 1'b1;
        pdA = v;
        tick();
        pvA = 1'b0;
    endtask

    // Ticks until the selected instance shows done; returns 20 if it never does.
    task automatic waitDone(input int which, output int n);
        n = 0;
        while (n < 20) begin
            if ((which == 0 && doneA === 1'b1) || (which == 1 && doneB === 1'b1) ||
                (which == 2 && doneC === 1'b1)) break;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
        tick();
        vecs++; if (readyA !== 1'b0) begin errs++; $display("FAIL reset_ready got %0b want 0", readyA); end
        vecs++; if (busyA !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", busyA); end
        vecs++; if (doneA !== 1'b0) begin errs++; $display("FAIL reset_done got %0b want 0", doneA); end
        vecs++; if (scoreA !== 48'd0) begin errs++; $display("FAIL reset_score got %0h want 0", scoreA); end
        vecs++; if ({matchA, ovfA} !== 2'b00) begin
            errs++; $display("FAIL reset_match_ovf got %b want 00", {matchA, ovfA});
        end
        // Start presented together with reset release is taken on the first high edge.
        reset  = 1'b1;
        startA = 1'b1;
        thrA   = 48'd0;
        tick();
        startA = 1'b0;
        vecs++; if (busyA !== 1'b1) begin errs++; $display("FAIL first_start_busy got %0b want 1", busyA); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        startWinA(48'd100);
        vecs++; if (busyA !== 1'b1) begin errs++; $display("FAIL basic_busy got %0b want 1", busyA); end
        vecs++; if (readyA !== 1'b1) begin errs++; $display("FAIL basic_ready got %0b want 1", readyA); end
        sendA(32'd10);
        sendA(32'd20);
        sendA(32'd30);
        sendA(32'd40);
        vecs++; if (readyA !== 1'b0) begin errs++; $display("FAIL basic_ready_after got %0b want 0", readyA); end
        vecs++; if (busyA !== 1'b1) begin errs++; $display("FAIL basic_busy_cmp got %0b want 1", busyA); end
        waitDone(0, n);
        vecs++; if (n !== 1) begin errs++; $display("FAIL basic_latency got %0d want 1", n); end
        vecs++; if (scoreA !== 48'd100) begin errs++; $display("FAIL basic_score got %0d want 100", scoreA); end
        vecs++; if (matchA !== 1'b1) begin errs++; $display("FAIL basic_match got %0b want 1", matchA); end
        vecs++; if (ovfA !== 1'b0) begin errs++; $display("FAIL basic_ovf got %0b want 0", ovfA); end
        vecs++; if (busyA !== 1'b0) begin errs++; $display("FAIL basic_busy_done got %0b want 0", busyA); end
        tick();
        vecs++; if (doneA !== 1'b0) begin errs++; $display("FAIL basic_done_pulse got %0b want 0", doneA); end
        vecs++; if (scoreA !== 48'd100) begin errs++; $display("FAIL basic_hold got %0d want 100", scoreA); end
    endtask

    task automatic test_gaps();
        int n;
        logic [31:0] vals [4];
        vals = '{32'd10, 32'd20, 32'd30, 32'd40};
        startWinA(48'd101);
        for (int i = 0; i < 4; i++) begin
            repeat (3) tick();
            if (i == 3) begin
                vecs++; if (readyA !== 1'b1) begin errs++; $display("FAIL gap_stall_ready got %0b want 1", readyA); end
            end
            sendA(vals[i]);
        end
        waitDone(0, n);
        vecs++; if (n !== 1) begin errs++; $display("FAIL gap_latency got %0d want 1", n); end
        vecs++; if (scoreA !== 48'd100) begin errs++; $display("FAIL gap_score got %0d want 100", scoreA); end
        vecs++; if (matchA !== 1'b0) begin errs++; $display("FAIL gap_match got %0b want 0", matchA); end
        tick();
    endtask

    task automatic test_saturate();
        int n;
        startB = 1'b1;
        thrB   = 33'd0;
        tick();
        startB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pvB = 1'b1;
            pdB = 32'hFFFF_FFFF;
            tick();
        end
        pvB = 1'b0;
        waitDone(1, n);
        vecs++; if (n !== 1) begin errs++; $display("FAIL sat_latency got %0d want 1", n); end
        vecs++; if (scoreB !== 33'h1_FFFF_FFFF) begin
            errs++; $display("FAIL sat_score got %0h want 1ffffffff", scoreB);
        end
        vecs++; if (ovfB !== 1'b1) begin errs++; $display("FAIL sat_ovf got %0b want 1", ovfB); end
        vecs++; if (matchB !== 1'b1) begin errs++; $display("FAIL sat_match got %0b want 1", matchB); end
        tick();
    endtask

    task automatic test_ignored_start();
        int n;
        int c0;
        c0 = doneCountA;
        startWinA(48'd50);
        sendA(32'd1);
        // Stray start with a lower threshold alongside a product.
        startA = 1'b1;
        thrA   = 48'd5;
        sendA(32'd2);
        startA = 1'b0;
        sendA(32'd3);
        vecs++; if (busyA !== 1'b1) begin errs++; $display("FAIL ign_busy got %0b want 1", busyA); end
        sendA(32'd4);
        waitDone(0, n);
        vecs++; if (n !== 1) begin errs++; $display("FAIL ign_latency got %0d want 1", n); end
        startA = 1'b1;
        thrA   = 48'd5;
        tick();
        startA = 1'b0;
        vecs++; if (busyA !== 1'b0) begin errs++; $display("FAIL ign_done_start got %0b want 0", busyA); end
        tick();
        vecs++; if (busyA !== 1'b0) begin errs++; $display("FAIL ign_idle_busy got %0b want 0", busyA); end
        vecs++; if (doneCountA - c0 !== 1) begin
            errs++; $display("FAIL ign_done_count got %0d want 1", doneCountA - c0);
        end
        vecs++; if (scoreA !== 48'd10) begin errs++; $display("FAIL ign_score got %0d want 10", scoreA); end
        vecs++; if (matchA !== 1'b0) begin errs++; $display("FAIL ign_match got %0b want 0", matchA); end
    endtask

    task automatic test_reset_mid();
        int n;
        int c0;
        c0 = doneCountA;
        startWinA(48'd100);
        sendA(32'd10);
        sendA(32'd20);
        #2;
        reset = 1'b0;
        #1;
        vecs++; if ({readyA, busyA, doneA, matchA, ovfA} !== 5'b0) begin
            errs++; $display("FAIL rst_mid_flags got %b want 00000", {readyA, busyA, doneA, matchA, ovfA});
        end
        vecs++; if (scoreA !== 48'd0) begin errs++; $display("FAIL rst_mid_score got %0d want 0", scoreA); end
        repeat (4) tick();
        vecs++; if (doneCountA !== c0) begin
            errs++; $display("FAIL rst_mid_no_done got %0d want %0d", doneCountA, c0);
        end
        reset = 1'b1;
        startWinA(48'd26);
        sendA(32'd5);
        sendA(32'd6);
        sendA(32'd7);
        sendA(32'd8);
        waitDone(0, n);
        vecs++; if (n !== 1) begin errs++; $display("FAIL rst_new_latency got %0d want 1", n); end
        vecs++; if (scoreA !== 48'd26) begin errs++; $display("FAIL rst_new_score got %0d want 26", scoreA); end
        vecs++; if (matchA !== 1'b1) begin errs++; $display("FAIL rst_new_match got %0b want 1", matchA); end
        tick();
    endtask

    task automatic test_idle_discard();
        int n;
        pvA = 1'b1;
        pdA = 32'd999;
        tick();
        tick();
        vecs++; if (readyA !== 1'b0) begin errs++; $display("FAIL idle_ready got %0b want 0", readyA); end
        startA = 1'b1;
        thrA   = 48'd5;
        tick();
        startA = 1'b0;
        pvA    = 1'b0;
        for (int i = 0; i < 4; i++) sendA(32'd1);
        waitDone(0, n);
        vecs++; if (scoreA !== 48'd4) begin errs++; $display("FAIL idle_score got %0d want 4", scoreA); end
        vecs++; if (matchA !== 1'b0) begin errs++; $display("FAIL idle_match got %0b want 0", matchA); end
        tick();
    endtask

    task automatic test_single();
        int n;
        startC = 1'b1;
        thrC   = 48'd7;
        tick();
        startC = 1'b0;
        pvC    = 1'b1;
        pdC    = 32'd7;
        tick();
        pvC    = 1'b0;
        vecs++; if (readyC !== 1'b0) begin errs++; $display("FAIL single_ready got %0b want 0", readyC); end
        waitDone(2, n);
        vecs++; if (n !== 1) begin errs++; $display("FAIL single_latency got %0d want 1", n); end
        vecs++; if (scoreC !== 48'd7) begin errs++; $display("FAIL single_score got %0d want 7", scoreC); end
        vecs++; if (matchC !== 1'b1) begin errs++; $display("FAIL single_match got %0b want 1", matchC); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        startWinA(48'd3);
        for (int i = 0; i < 4; i++) sendA(32'd1);
        waitDone(0, n);
        vecs++; if (scoreA !== 48'd4) begin errs++; $display("FAIL b2b_first got %0d want 4", scoreA); end
        tick();
        startWinA(48'd8);
        vecs++; if (busyA !== 1'b1) begin errs++; $display("FAIL b2b_accept got %0b want 1", busyA); end
        for (int i = 0; i < 4; i++) sendA(32'd2);
        waitDone(0, n);
        vecs++; if (n !== 1) begin errs++; $display("FAIL b2b_latency got %0d want 1", n); end
        vecs++; if (scoreA !== 48'd8) begin errs++; $display("FAIL b2b_score got %0d want 8", scoreA); end
        vecs++; if (matchA !== 1'b1) begin errs++; $display("FAIL b2b_match got %0b want 1", matchA); end
        tick();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        doneCountA = 0;
        reset  = 1'b1;
        startA = 1'b0; pvA = 1'b0; thrA = '0; pdA = '0;
        startB = 1'b0; pvB = 1'b0; thrB = '0; pdB = '0;
        startC = 1'b0; pvC = 1'b0; thrC = '0; pdC = '0;

        test_reset();
        test_basic();
        test_gaps();
        test_saturate();
        test_ignored_start();
        test_reset_mid();
        test_idle_discard();
        test_single();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
